alu_sequencer: RTL and testbench

- Control-side initiator for the register/ALU datapath.
- Accepts one ALU command (opcode plus two 32-bit operands) over a valid/ready handshake.
- Sequences the datapath's operand loads into ra and rb, waits for the ALU result, then strobes it into rz.
- Captures the 64-bit rz value and returns it to the requester over a second valid/ready handshake.
- Sits between the instruction control logic and the datapath. It drives the datapath's op_select, register_select and register_in, and reads back the rz output.

---
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command, steps the datapath through the
// ra/rb operand loads, the ALU settle window and the rz strobe, then hands
// the captured 64-bit rz value back over a valid/ready result interface.
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int SEL_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [31:0]          cmd_a,
  input  logic [31:0]          cmd_b,
  output logic [3:0]           op_select,
  output logic [SEL_WIDTH-1:0] register_select,
  output logic [31:0]          register_in,
  input  logic [63:0]          rz_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [63:0]          result_data,
  output logic                 busy
);

  // A zero settle time would skip EXEC entirely; clamp it to one cycle.
  localparam int          EXEC_EFF  = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam logic [31:0] EXEC_LAST = 32'(EXEC_EFF - 1);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_RA   = 3'b001;
  localparam logic [2:0] SEL_RB   = 3'b010;
  localparam logic [2:0] SEL_RZ   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE_Z = 3'd4,
    S_CAPTURE = 3'd5,
    S_RESULT  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  op_select_q, op_select_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] reg_in_q, reg_in_d;
  logic        result_valid_q, result_valid_d;
  logic [63:0] result_data_q, result_data_d;

  // Next-state logic: command latch, settle counter and result capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    result_data_d = result_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = S_LOAD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        cnt_d   = EXEC_LAST;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == 32'd0) begin
          state_d = S_WRITE_Z;
        end else begin
          cnt_d   = cnt_q - 32'd1;
          state_d = S_EXEC;
        end
      end
      S_WRITE_Z: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // rz was loaded on the previous edge, so rz_data is valid now.
        result_data_d = rz_data;
        state_d       = S_RESULT;
      end
      S_RESULT: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every datapath output is a flop.
  always_comb begin
    op_select_d    = 4'h0;
    sel_d          = SEL_NONE;
    reg_in_d       = 32'h0;
    result_valid_d = 1'b0;
    case (state_d)
      S_LOAD_A: begin
        op_select_d = op_d;
        sel_d       = SEL_RA;
        reg_in_d    = a_d;
      end
      S_LOAD_B: begin
        op_select_d = op_d;
        sel_d       = SEL_RB;
        reg_in_d    = b_d;
      end
      S_EXEC:    op_select_d = op_d;
      S_WRITE_Z: begin
        op_select_d = op_d;
        sel_d       = SEL_RZ;
      end
      S_RESULT:  result_valid_d = 1'b1;
      default: begin
        op_select_d    = 4'h0;
        sel_d          = SEL_NONE;
        reg_in_d       = 32'h0;
        result_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; clear aborts any sequence in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q        <= S_IDLE;
      op_q           <= 4'h0;
      a_q            <= 32'h0;
      b_q            <= 32'h0;
      cnt_q          <= 32'h0;
      op_select_q    <= 4'h0;
      sel_q          <= SEL_NONE;
      reg_in_q       <= 32'h0;
      result_valid_q <= 1'b0;
      result_data_q  <= 64'h0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      cnt_q          <= cnt_d;
      op_select_q    <= op_select_d;
      sel_q          <= sel_d;
      reg_in_q       <= reg_in_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
    end
  end

  // Only the low three select bits are ever driven; the rest stay zero.
  always_comb begin
    register_select      = {SEL_WIDTH{1'b0}};
    register_select[2:0] = sel_q;
  end

  // cmd_ready is gated by clear so nothing is accepted on a reset edge.
  assign cmd_ready    = (state_q == S_IDLE) && !clear;
  assign busy         = (state_q != S_IDLE);
  assign op_select    = op_select_q;
  assign register_in  = reg_in_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (EXEC_CYCLES 1 and 3), each driving
// a small register/ALU datapath model; a scoreboard queue per instance holds
// the expected results pushed at command accept.
module tb_alu_sequencer;
  localparam int SW = 16;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          acc;
  } exp_t;

  logic          clock = 1'b0;
  logic          clear;
  logic          cv  [2];
  logic          cr  [2];
  logic          rv  [2];
  logic          rr  [2];
  logic          bz  [2];
  logic [3:0]    cop [2];
  logic [3:0]    ops [2];
  logic [31:0]   ca  [2];
  logic [31:0]   cb  [2];
  logic [31:0]   rin [2];
  logic [SW-1:0] sel [2];
  logic [63:0]   rd  [2];
  logic [31:0]   ra  [2] = '{32'h0, 32'h0};
  logic [31:0]   rb  [2] = '{32'h0, 32'h0};
  logic [63:0]   rz  [2] = '{64'h0, 64'h0};

  exp_t q [2][$];
  bit   pending [2];
  bit   prev_v  [2];
  logic [63:0] last_rd [2];
  int   lat [2] = '{5, 7};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_sequencer #(.EXEC_CYCLES(1), .SEL_WIDTH(SW)) dut0 (
    .clock(clock), .clear(clear), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .cmd_op(cop[0]), .cmd_a(ca[0]), .cmd_b(cb[0]), .op_select(ops[0]),
    .register_select(sel[0]), .register_in(rin[0]), .rz_data(rz[0]),
    .result_valid(rv[0]), .result_ready(rr[0]), .result_data(rd[0]), .busy(bz[0])
  );

  alu_sequencer #(.EXEC_CYCLES(3), .SEL_WIDTH(SW)) dut1 (
    .clock(clock), .clear(clear), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .cmd_op(cop[1]), .cmd_a(ca[1]), .cmd_b(cb[1]), .op_select(ops[1]),
    .register_select(sel[1]), .register_in(rin[1]), .rz_data(rz[1]),
    .result_valid(rv[1]), .result_ready(rr[1]), .result_data(rd[1]), .busy(bz[1])
  );

  // ALU behaviour of the modelled datapath: op 3 adds, op A concatenates.
  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h3:    return {32'h0, a + b};
      4'hA:    return {a, b};
      default: return {a ^ b, a & b};
    endcase
  endfunction

  // Datapath register model driven by each sequencer.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (sel[i][0]) ra[i] <= rin[i];
      if (sel[i][1]) rb[i] <= rin[i];
      if (sel[i][2]) rz[i] <= alu_model(ops[i], ra[i], rb[i]);
    end
  end

  task automatic chk_eq(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): actual %h required %h", name, inst, act, exp);
    end
  endtask

  task automatic fail_now(input int inst, input string name);
    checks++;
    errors++;
    $display("FAIL %s (dut%0d): bound expired", name, inst);
  endtask

  // Monitor/scoreboard: push at accept, pop and compare when a result appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          q[i].delete();
          pending[i] = 1'b0;
          prev_v[i]  = 1'b0;
        end else begin
          chk_eq(i, "sel_shape", 64'(sel[i]), ((sel[i][SW-1:3] == '0) && $onehot0(sel[i])) ? 64'(sel[i]) : 64'h0);
          if (sel[i] != '0) begin
            if (q[i].size() == 0) begin
              fail_now(i, "select_without_command");
            end else begin
              chk_eq(i, "op_select", 64'(ops[i]), 64'(q[i][0].op));
              if (sel[i] == 16'h0001) chk_eq(i, "register_in_a", 64'(rin[i]), 64'(q[i][0].a));
              if (sel[i] == 16'h0002) chk_eq(i, "register_in_b", 64'(rin[i]), 64'(q[i][0].b));
            end
          end
          if (!bz[i]) chk_eq(i, "idle_op_select", 64'(ops[i]), 64'h0);
          if (cv[i] && cr[i]) begin
            chk_eq(i, "accept_after_handshake", 64'(pending[i]), 64'h0);
            e.op = cop[i]; e.a = ca[i]; e.b = cb[i];
            e.res = alu_model(cop[i], ca[i], cb[i]);
            e.acc = cyc + 1;
            q[i].push_back(e);
            pending[i] = 1'b1;
          end
          if (rv[i] && !prev_v[i]) begin
            if (q[i].size() == 0) begin
              fail_now(i, "unexpected_result");
            end else begin
              e = q[i].pop_front();
              chk_eq(i, "result_data", rd[i], e.res);
              chk_eq(i, "latency", 64'(cyc - e.acc), 64'(lat[i]));
            end
            last_rd[i] = rd[i];
          end else if (rv[i]) begin
            chk_eq(i, "result_stable", rd[i], last_rd[i]);
          end
          if (rv[i] && rr[i]) pending[i] = 1'b0;
          prev_v[i] = rv[i];
        end
      end
    end
  end

  task automatic send(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit keep, output int acc);
    int n;
    @(posedge clock); #1;
    cop[i] = op; ca[i] = a; cb[i] = b; cv[i] = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clock);
      if (cr[i]) break;
    end
    if (n == 100) fail_now(i, "accept_timeout");
    @(posedge clock); #1;
    acc = cyc;
    if (!keep) cv[i] = 1'b0;
  endtask

  task automatic wait_result(input int i);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clock);
      if (rv[i]) break;
    end
    if (n == 100) fail_now(i, "result_timeout");
  endtask

  task automatic drain(input int i);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clock);
      if (q[i].size() == 0 && !pending[i]) break;
    end
    if (n == 300) fail_now(i, "drain_timeout");
  endtask

  initial begin
    int s2 [5] = '{1, 2, 0, 4, 0};
    int o2 [5] = '{3, 3, 3, 3, 0};
    int s4 [7] = '{1, 2, 0, 0, 0, 4, 0};
    int acc1, acc2, sent;
    bit acc;
    logic [63:0] held;

    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; rr[i] = 1'b1; cop[i] = 4'h0; ca[i] = 32'h0; cb[i] = 32'h0;
    end
    cv[0] = 1'b1;

    // Reset held two cycles with a command offered.
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      chk_eq(0, "reset_cmd_ready", 64'(cr[0]), 64'h0);
      chk_eq(0, "reset_busy", 64'(bz[0]), 64'h0);
      chk_eq(0, "reset_sel", 64'(sel[0]), 64'h0);
      chk_eq(0, "reset_op", 64'(ops[0]), 64'h0);
      chk_eq(0, "reset_reg_in", 64'(rin[0]), 64'h0);
      chk_eq(0, "reset_valid", 64'(rv[0]), 64'h0);
      chk_eq(0, "reset_data", rd[0], 64'h0);
    end
    @(posedge clock); #1;
    clear = 1'b0; cv[0] = 1'b0;
    @(negedge clock);
    chk_eq(0, "ready_after_reset", 64'(cr[0]), 64'h1);

    // Single add: selects 1,2,0,4 then a one-cycle result of 0xC.
    send(0, 4'h3, 32'h5, 32'h7, 1'b0, acc1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk_eq(0, "trace_sel", 64'(sel[0]), 64'(s2[k]));
      chk_eq(0, "trace_op", 64'(ops[0]), 64'(o2[k]));
      if (k == 0) chk_eq(0, "trace_in_a", 64'(rin[0]), 64'h5);
      if (k == 1) chk_eq(0, "trace_in_b", 64'(rin[0]), 64'h7);
    end
    @(negedge clock);
    chk_eq(0, "single_valid", 64'(rv[0]), 64'h1);
    chk_eq(0, "single_data", rd[0], 64'hC);
    @(negedge clock);
    chk_eq(0, "single_valid_drop", 64'(rv[0]), 64'h0);
    chk_eq(0, "single_busy_drop", 64'(bz[0]), 64'h0);

    // Backpressure with an ignored command pulse.
    rr[0] = 1'b0;
    send(0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0, acc1);
    wait_result(0);
    held = rd[0];
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (k == 3) begin
        cop[0] = 4'h3; ca[0] = $urandom; cb[0] = $urandom; cv[0] = 1'b1;
      end
      if (k == 6) cv[0] = 1'b0;
      @(negedge clock);
      chk_eq(0, "bp_valid", 64'(rv[0]), 64'h1);
      chk_eq(0, "bp_cmd_ready", 64'(cr[0]), 64'h0);
      chk_eq(0, "bp_data", rd[0], held);
    end
    @(posedge clock); #1;
    rr[0] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_eq(0, "bp_idle_busy", 64'(bz[0]), 64'h0);
    chk_eq(0, "bp_idle_valid", 64'(rv[0]), 64'h0);
    chk_eq(0, "bp_idle_ready", 64'(cr[0]), 64'h1);
    chk_eq(0, "bp_data_hold", rd[0], held);

    // Longer settle time on the second instance.
    send(1, 4'hA, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, acc1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      chk_eq(1, "exec3_sel", 64'(sel[1]), 64'(s4[k]));
    end
    @(negedge clock);
    chk_eq(1, "exec3_valid", 64'(rv[1]), 64'h1);
    chk_eq(1, "exec3_data", rd[1], 64'hDEAD_BEEF_1234_5678);
    drain(1);

    // Clear in EXEC aborts without an rz strobe.
    send(0, 4'h3, $urandom, $urandom, 1'b0, acc1);
    @(posedge clock);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk_eq(0, "abort_sel", 64'(sel[0]), 64'h0);
    chk_eq(0, "abort_op", 64'(ops[0]), 64'h0);
    chk_eq(0, "abort_busy", 64'(bz[0]), 64'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk_eq(0, "abort_no_rz", 64'(sel[0][2]), 64'h0);
    end
    send(0, 4'hA, $urandom, $urandom, 1'b0, acc1);
    drain(0);

    // Back-to-back with cmd_valid held high.
    send(0, 4'h3, $urandom, $urandom, 1'b1, acc1);
    send(0, 4'hA, $urandom, $urandom, 1'b0, acc2);
    chk_eq(0, "b2b_gap", 64'(acc2 - acc1), 64'd7);
    drain(0);

    // Randomized commands with random result backpressure.
    sent = 0;
    for (int c = 0; c < 4000 && (sent < 40 || q[0].size() != 0 || pending[0]); c++) begin
      @(negedge clock);
      acc = cv[0] && cr[0];
      @(posedge clock); #1;
      rr[0] = ($urandom_range(0, 3) != 0);
      if (acc) begin
        cv[0] = 1'b0;
        sent++;
      end
      if (!cv[0] && sent < 40 && $urandom_range(0, 1) == 1) begin
        cop[0] = 4'($urandom_range(0, 15)); ca[0] = $urandom; cb[0] = $urandom; cv[0] = 1'b1;
      end
    end
    cv[0] = 1'b0;
    rr[0] = 1'b1;
    drain(0);
    chk_eq(0, "random_sent", 64'(sent), 64'd40);
    chk_eq(0, "scoreboard_empty", 64'(q[0].size() + q[1].size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
